uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial receive engine of the UART peripheral.
- Converts the `uart_rx` pin into bytes with per-byte parity and framing status, plus an overrun indication.
- Sits between the pin and the register file / bus slave (APB, AHB, Avalon, SIF front-ends). It feeds them through a valid/ready holding register.
- Runtime configuration comes from the control register.

Parameters:
- DW, 8, data bits per frame (fixed frame width; 5..8 supported).
- BDW, 16, width of the baud divider input.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en  input  1  receiver enable; 0 forces IDLE and drops the frame in progress
- baud_div  input  BDW  clocks per bit minus 1 (minimum 3)
- par_mode  input  2  parity: 0 none, 1 even, 2 odd, 3 reserved (treated as none)
- stop2  input  1  1 = check two stop bits
- uart_rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  DW  received byte
- rx_valid  output  1  rx_data/par_err/frm_err valid
- rx_ready  input  1  consumer accepts on rx_valid & rx_ready
- par_err  output  1  parity mismatch for the held byte
- frm_err  output  1  stop bit sampled low for the held byte
- ovr_err  output  1  one-cycle pulse: frame completed while rx_valid & !rx_ready, new byte lost
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; rx_data = 0; FSM = IDLE; synchronizer flops preset to 1.
- Input path: uart_rx passes a 2-flop synchronizer plus one history flop. Start is the falling edge seen on the synchronized value.
- Bit counter: bit_cnt counts 0..baud_div; sample point is bit_cnt == baud_div >> 1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE -> START: on falling edge with en=1; bit_cnt cleared.
- START: at the mid-point sample.
  - Line 0 -> DATA, bit index = 0.
  - Line 1 -> IDLE (glitch rejection); no output, no error.
- DATA: sample at the mid-point of each bit and shift in LSB first.
  - After bit DW-1: go to PARITY if par_mode is 1 or 2, else STOP1.
- PARITY: compute expected parity (even: XOR of data; odd: its inverse) and compare with the sample; mismatch sets internal p_err.
- STOP1: a low sample sets internal f_err.
  - stop2=1 -> STOP2.
  - Otherwise the frame completes at this sample and the FSM returns to IDLE at once, so a start edge during the remaining half stop bit is still caught.
- STOP2: same check as STOP1; the frame completes at its sample.
- Frame complete, holding register empty or being accepted in the same cycle:
  - On the next clk, rx_data, par_err and frm_err load and rx_valid = 1.
  - Latency is 1 cycle after the final mid-bit sample.
- Frame complete, rx_valid=1 and rx_ready=0:
  - ovr_err pulses for 1 cycle.
  - Held byte and flags are unchanged; the new byte is discarded.
- Handshake:
  - rx_valid stays high until the rx_valid & rx_ready cycle, then clears.
  - Load and accept in the same cycle: load wins and rx_valid stays 1.
- en deasserted mid-frame: FSM -> IDLE on the next clk. The held byte is kept; no flags.
- baud_div must be stable while busy=1; changing it mid-frame is undefined.
- A break condition (line low ≥ one frame) yields a byte of 0x00 with frm_err=1. The FSM then waits in IDLE for a fresh falling edge; a line held low does not retrigger.

Decomposition:
- uart_pkg holds:
  - the parity enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - the FSM state enum
  - the default BDW constant
- The same package is reused by the transmitter and the bus register maps.
- One sub-module: uart_sync2, the 2-flop synchronizer with preset on rst. It is shared with the CTS input.

Test Plan:
- Basic frame: baud_div=15, par_mode=0, stop2=0, send 0x55 -> rx_valid rises 153±2 clocks after the start edge, rx_data=0x55, par_err=0, frm_err=0.
- Parity: par_mode=1 with 0xA3 and correct parity bit 0 -> par_err=0. Same byte with parity bit 1 -> par_err=1. par_mode=2 with parity 1 -> par_err=0.
- Framing: stop bit driven 0 on 0x3C -> rx_data=0x3C, frm_err=1. stop2=1 with the second stop bit low -> frm_err=1.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> ovr_err one-cycle pulse at the end of 0x22, rx_data stays 0x11. Then rx_ready=1 -> rx_valid drops next cycle.
- Glitch rejection: 4-clock low pulse on uart_rx with baud_div=15 -> no rx_valid, busy returns to 0 after 8 clocks. A following 0xFF frame is received correctly.
- Reset/enable mid-frame: assert rst, or drop en, during DATA bit 3 -> all outputs 0 (rst) or held byte kept (en), busy=0. The next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and default widths.
// Also used by the transmitter and the bus register maps.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  localparam int UART_BDW = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous idle-high inputs (RX data, CTS).
// Presets to 1 so reset never looks like a start edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: mid-bit sampling FSM feeding a valid/ready holding
// register with per-byte parity/framing flags and an overrun pulse.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DW  = 8,
  parameter int BDW = UART_BDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [BDW-1:0] baud_div,
  input  logic [1:0]     par_mode,
  input  logic           stop2,
  input  logic           uart_rx,
  output logic [DW-1:0]  rx_data,
  output logic           rx_valid,
  input  logic           rx_ready,
  output logic           par_err,
  output logic           frm_err,
  output logic           ovr_err,
  output logic           busy
);

  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DW - 1);

  rx_state_e      state_q, state_d;
  logic           rx_sync, rx_hist, fall;
  logic [BDW-1:0] bit_cnt_q;
  logic [IW-1:0]  bit_idx_q;
  logic [DW-1:0]  shreg_q;
  logic           p_err_q, f_err_q;
  logic           tick, par_on;
  logic           start_ok, shift_en, par_chk, stop_chk, frame_done;
  logic           fin_ferr, load, accept;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rx_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_hist <= 1'b1;
    else     rx_hist <= rx_sync;
  end

  assign fall   = rx_hist & ~rx_sync;
  assign tick   = (bit_cnt_q == (baud_div >> 1));
  assign par_on = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stop_chk   = 1'b0;
    frame_done = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (fall) state_d = ST_START;
        ST_START: begin
          if (tick) begin
            // A high mid-point means the edge was a glitch, not a start bit.
            start_ok = ~rx_sync;
            state_d  = rx_sync ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_en = 1'b1;
            if (bit_idx_q == LAST_IDX) state_d = par_on ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (tick) begin
            par_chk = 1'b1;
            state_d = ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (tick) begin
            stop_chk = 1'b1;
            if (stop2) begin
              state_d = ST_STOP2;
            end else begin
              // Leave at the stop mid-point so a start edge in the last half bit is caught.
              state_d    = ST_IDLE;
              frame_done = 1'b1;
            end
          end
        end
        ST_STOP2: begin
          if (tick) begin
            stop_chk   = 1'b1;
            state_d    = ST_IDLE;
            frame_done = 1'b1;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      p_err_q   <= 1'b0;
      f_err_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE || !en)   bit_cnt_q <= '0;
      else if (bit_cnt_q == baud_div)  bit_cnt_q <= '0;
      else                             bit_cnt_q <= bit_cnt_q + 1'b1;
      if (start_ok) begin
        bit_idx_q <= '0;
        p_err_q   <= 1'b0;
        f_err_q   <= 1'b0;
      end
      if (shift_en) bit_idx_q <= bit_idx_q + 1'b1;
      if (par_chk)  p_err_q <= (((^shreg_q) ^ (par_mode == PAR_ODD)) != rx_sync);
      if (stop_chk && !rx_sync) f_err_q <= 1'b1;
    end
  end

  // LSB arrives first, so shift right and insert at the top.
  always_ff @(posedge clk) begin
    if (shift_en) shreg_q <= {rx_sync, shreg_q[DW-1:1]};
  end

  assign accept   = rx_valid & rx_ready;
  assign load     = frame_done & (~rx_valid | rx_ready);
  assign fin_ferr = f_err_q | ~rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      ovr_err <= frame_done & rx_valid & ~rx_ready;
      if (load) begin
        rx_data  <= shreg_q;
        par_err  <= p_err_q;
        frm_err  <= fin_ferr;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed vector table, hand-written
// corner sequences and random frames against a frame-level reference model.
module tb_uart_rx_core;

  localparam int DW  = 8;
  localparam int BDW = 16;

  logic           clk = 1'b0;
  logic           rst, en, stop2, uart_rx, rx_ready;
  logic [BDW-1:0] baud_div;
  logic [1:0]     par_mode;
  logic [DW-1:0]  rx_data;
  logic           rx_valid, par_err, frm_err, ovr_err, busy;

  always #5 clk = ~clk;

  uart_rx_core #(.DW(DW), .BDW(BDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .baud_div (baud_div),
    .par_mode (par_mode),
    .stop2    (stop2),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .par_err  (par_err),
    .frm_err  (frm_err),
    .ovr_err  (ovr_err),
    .busy     (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       s2;
    logic       pbit;
    logic       sa;
    logic       sb;
    logic [7:0] e_d;
    logic       e_p;
    logic       e_f;
  } vec_t;

  vec_t       vecs[8];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         baud = 15;
  int         start_cyc = 0;
  int         rise_cyc = -1;
  int         ovr_cnt = 0;
  logic       vld_prev = 1'b0;
  logic [9:0] acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !vld_prev) rise_cyc = cyc;
    vld_prev = rx_valid;
    if (ovr_err) ovr_cnt++;
    if (rx_valid && rx_ready) acc_q.push_back({par_err, frm_err, rx_data});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // Expected {par_err, frm_err, data} computed from the frame's bits.
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] pm,
                                       input logic s2, input logic pbit,
                                       input logic sa, input logic sb);
    logic even_bit, want, pe, fe;
    even_bit = ($countones(d) % 2) == 1;
    want     = (pm == 2'd2) ? ~even_bit : even_bit;
    pe       = (pm == 2'd1 || pm == 2'd2) ? (pbit != want) : 1'b0;
    fe       = !sa || (s2 && !sb);
    return {pe, fe, d};
  endfunction

  task automatic set_baud(input int b);
    baud     = b;
    baud_div = BDW'(b);
  endtask

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // cut >= 0 stops halfway through data bit 'cut'; last_len > 0 shortens the
  // final stop bit and omits the trailing idle bit.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                            input logic pbit, input logic sa, input logic sb,
                            input int cut, input int last_len);
    int bl, ll;
    bl = baud + 1;
    ll = (last_len > 0) ? last_len : bl;
    start_cyc = cyc;
    drive_bit(1'b0, bl);
    for (int i = 0; i < 8; i++) begin
      if (cut == i) begin
        drive_bit(d[i], bl / 2);
        return;
      end
      drive_bit(d[i], bl);
    end
    if (pm == 2'd1 || pm == 2'd2) drive_bit(pbit, bl);
    if (s2) begin
      drive_bit(sa, bl);
      drive_bit(sb, ll);
    end else begin
      drive_bit(sa, ll);
    end
    if (last_len == 0) drive_bit(1'b1, bl);
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 200 && !rx_valid; k++) @(negedge clk);
    n_chk++;
    if (rx_valid) n_pass++;
    else $display("FAIL wait_valid: rx_valid stayed 0 for %0d cycles, required 1", k);
  endtask

  task automatic accept_byte();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("accept clears rx_valid", rx_valid, 0);
  endtask

  task automatic check_held(input string tag, input logic [7:0] d, input logic p, input logic f);
    chk({tag, " data"}, rx_data, d);
    chk({tag, " par_err"}, par_err, p);
    chk({tag, " frm_err"}, frm_err, f);
  endtask

  initial begin
    int         lat, bc;
    logic [9:0] got, exp;
    int         blist[4];
    logic [7:0] d;
    logic [1:0] pm;
    logic       s2, pb, sa, sb;

    vecs[0] = '{8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[2] = '{8'hA3, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[3] = '{8'hA3, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'h5A, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[6] = '{8'h0F, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[7] = '{8'h96, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h96, 1'b1, 1'b0};

    rst = 1'b1; en = 1'b0; stop2 = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0;
    par_mode = 2'd0;
    set_baud(15);
    repeat (3) @(negedge clk);
    chk("reset outputs", {rx_valid, par_err, frm_err, ovr_err, busy, rx_data}, 0);
    rst = 1'b0; en = 1'b1;
    repeat (4) @(negedge clk);

    // Latency counted from the synchronized start edge (2 clocks after the pin).
    send_frame(8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_valid();
    lat = rise_cyc - start_cyc - 2;
    n_chk++;
    if (lat >= 151 && lat <= 155) n_pass++;
    else $display("FAIL latency: got %0d clocks, required 153+-2", lat);
    check_held("basic", 8'h55, 1'b0, 1'b0);
    accept_byte();

    for (int i = 0; i < 8; i++) begin
      par_mode = vecs[i].pm;
      stop2    = vecs[i].s2;
      send_frame(vecs[i].d, vecs[i].pm, vecs[i].s2, vecs[i].pbit, vecs[i].sa, vecs[i].sb, -1, 0);
      wait_valid();
      check_held($sformatf("vec%0d", i), vecs[i].e_d, vecs[i].e_p, vecs[i].e_f);
      accept_byte();
    end
    par_mode = 2'd0;
    stop2    = 1'b0;

    // Overrun: second frame lost while the first is still held.
    send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_valid();
    ovr_cnt = 0;
    send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    repeat (2) @(negedge clk);
    chk("ovr pulse cycles", ovr_cnt, 1);
    chk("ovr keeps valid", rx_valid, 1);
    check_held("ovr held", 8'h11, 1'b0, 1'b0);
    accept_byte();

    // Glitch: 4-clock low pulse.
    bc = 0;
    uart_rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    uart_rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("glitch busy cycles", bc, 8);
    chk("glitch no valid", rx_valid, 0);
    send_frame(8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_valid();
    check_held("after glitch", 8'hFF, 1'b0, 1'b0);
    accept_byte();

    // Break: line held low well beyond one frame.
    uart_rx = 1'b0;
    repeat (12 * 16) @(negedge clk);
    wait_valid();
    check_held("break", 8'h00, 1'b0, 1'b1);
    accept_byte();
    repeat (48) @(negedge clk);
    chk("break no retrigger valid", rx_valid, 0);
    chk("break no retrigger busy", busy, 0);
    uart_rx = 1'b1;
    repeat (32) @(negedge clk);

    // Start edge inside the second half of the stop bit.
    rx_ready = 1'b1;
    acc_q.delete();
    send_frame(8'hC3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 11);
    send_frame(8'h3A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    repeat (2) @(negedge clk);
    chk("b2b count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("b2b first", acc_q[0], {2'b00, 8'hC3});
      chk("b2b second", acc_q[1], {2'b00, 8'h3A});
    end
    rx_ready = 1'b0;

    // Reset during data bit 3.
    send_frame(8'h42, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_valid();
    send_frame(8'hB7, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 0);
    chk("busy before rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid-frame outputs", {rx_valid, par_err, frm_err, ovr_err, busy, rx_data}, 0);
    uart_rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (32) @(negedge clk);
    send_frame(8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_valid();
    check_held("after rst", 8'h81, 1'b0, 1'b0);
    accept_byte();

    // Enable dropped during data bit 3 with a byte held.
    send_frame(8'h42, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_valid();
    send_frame(8'hB7, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 0);
    chk("busy before en drop", busy, 1);
    en = 1'b0;
    @(negedge clk);
    chk("en drop busy", busy, 0);
    chk("en drop keeps valid", rx_valid, 1);
    check_held("en drop held", 8'h42, 1'b0, 1'b0);
    uart_rx = 1'b1;
    repeat (32) @(negedge clk);
    en = 1'b1;
    accept_byte();
    send_frame(8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_valid();
    check_held("after en", 8'h81, 1'b0, 1'b0);
    accept_byte();

    // Random frames against the reference model.
    blist = '{3, 5, 7, 15};
    ovr_cnt  = 0;
    rx_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      set_baud(blist[$urandom_range(0, 3)]);
      d  = 8'($urandom);
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom);
      pb = 1'($urandom);
      sa = ($urandom_range(0, 5) != 0);
      sb = ($urandom_range(0, 5) != 0);
      par_mode = pm;
      stop2    = s2;
      acc_q.delete();
      send_frame(d, pm, s2, pb, sa, sb, -1, 0);
      repeat (2) @(negedge clk);
      exp = model(d, pm, s2, pb, sa, sb);
      chk($sformatf("rand%0d count", i), acc_q.size(), 1);
      if (acc_q.size() > 0) begin
        got = acc_q.pop_front();
        chk($sformatf("rand%0d frame", i), got, exp);
      end
    end
    chk("rand no overrun", ovr_cnt, 0);
    rx_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
